// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, word/block types, key-expansion FSM states,
// Rcon table and the forward S-box used by the key schedule and SubBytes.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8->8 forward AES S-box.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_fwd(in_i);

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands Key into RK0..RK10, one round per cycle.
// Build option KEYEXP_REGOUT_EN registers the RoundKey read port.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [KEY_W-1:0] Key,
    input  logic [3:0]       KeySel,
    output logic [KEY_W-1:0] RoundKey,
    output logic             Busy,
    output logic             Ry
);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    block_t     w_q, w_d;
    block_t     rk_q [0:NR];

    logic       wr_en;
    logic [3:0] wr_idx;
    block_t     wr_data;

    word_t  w0, w1, w2, w3, rot, sub, t;
    word_t  n0, n1, n2, n3;
    block_t w_next;
    block_t rd_data;

    assign w0  = w_q[127:96];
    assign w1  = w_q[95:64];
    assign w2  = w_q[63:32];
    assign w3  = w_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.in_i(rot[31:24]), .out_o(sub[31:24]));
    aes_sbox u_sbox1 (.in_i(rot[23:16]), .out_o(sub[23:16]));
    aes_sbox u_sbox2 (.in_i(rot[15:8]),  .out_o(sub[15:8]));
    aes_sbox u_sbox3 (.in_i(rot[7:0]),   .out_o(sub[7:0]));

    assign t      = sub ^ {rcon(rnd_q), 24'h0};
    assign n0     = w0 ^ t;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;
    assign w_next = {n0, n1, n2, n3};

    // Key is captured at the accepting edge; LOAD then commits it as RK0.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        w_d     = w_q;
        wr_en   = 1'b0;
        wr_idx  = rnd_q;
        wr_data = w_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    w_d     = Key;
                    rnd_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wr_en   = 1'b1;
                wr_idx  = '0;
                rnd_d   = 4'd1;
                state_d = EXPAND;
            end
            EXPAND: begin
                wr_en   = 1'b1;
                wr_data = w_next;
                w_d     = w_next;
                if (rnd_q == 4'(NR)) state_d = DONE;
                else                 rnd_d   = rnd_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            w_q     <= '0;
            for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            w_q     <= w_d;
            if (wr_en) rk_q[wr_idx] <= wr_data;
        end
    end

    assign Busy = (state_q == LOAD) || (state_q == EXPAND);
    assign Ry   = (state_q == DONE);

    always_comb begin
        rd_data = '0;
        if (KeySel <= 4'(NR)) rd_data = rk_q[KeySel];
    end

`ifdef KEYEXP_REGOUT_EN
    block_t rk_out_q;

    always_ff @(posedge Clk) begin
        if (Rst) rk_out_q <= '0;
        else     rk_out_q <= rd_data;
    end

    assign RoundKey = rk_out_q;
`else
    assign RoundKey = rd_data;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion against a FIPS-197 style key schedule model.
module tb_aes_key_expansion;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [127:0] Key;
    logic [3:0]   KeySel;
    logic [127:0] RoundKey;
    logic         Busy;
    logic         Ry;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expansion dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Key      (Key),
        .KeySel   (KeySel),
        .RoundKey (RoundKey),
        .Busy     (Busy),
        .Ry       (Ry)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if ((q & 8'h80) != 0) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
    endfunction

    // Word-indexed schedule: w[i] = w[i-4] ^ f(w[i-1]).
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_clear();
        for (int r = 0; r < 11; r++) exp_rk[r] = '0;
    endtask

    task automatic start_exp(input logic [127:0] k);
        Key   = k;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (Busy !== 1'b1 || Ry !== 1'b0) begin
                errors++;
                $display("FAIL %s busy phase %0d: Busy=%b Ry=%b expected Busy=1 Ry=0", tag, i, Busy, Ry);
            end
            @(negedge Clk);
        end
        checks++;
        if (Busy !== 1'b0 || Ry !== 1'b1) begin
            errors++;
            $display("FAIL %s done: Busy=%b Ry=%b expected Busy=0 Ry=1", tag, Busy, Ry);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (Ry !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (Ry !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: Ry=%b expected 1 within 40 cycles", tag, Ry);
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] e;
        for (int s = 0; s < 16; s++) begin
            KeySel = 4'(s);
            @(negedge Clk);
            e = '0;
            if (s <= 10) e = exp_rk[s];
            checks++;
            if (RoundKey !== e) begin
                errors++;
                $display("FAIL %s RK[%0d] got %h expected %h", tag, s, RoundKey, e);
            end
        end
        KeySel = '0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; Key = '0; KeySel = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Ry !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags Busy=%b Ry=%b expected 0 0", Busy, Ry);
        end
        model_clear();
        check_all("reset_storage");
        // Rst and Start together: Rst wins, no expansion begins.
        Rst = 1'b1; Start = 1'b1; Key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge Clk);
        Rst = 1'b0; Start = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Ry !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority Busy=%b Ry=%b expected 0 0", Busy, Ry);
        end
    endtask

    task automatic test_fips();
        model_expand(FIPS_KEY);
        checks++;
        if (exp_rk[1] !== FIPS_RK1 || exp_rk[10] !== FIPS_RK10) begin
            errors++;
            $display("FAIL model_fips RK1=%h RK10=%h expected %h %h", exp_rk[1], exp_rk[10], FIPS_RK1, FIPS_RK10);
        end
        start_exp(FIPS_KEY);
        Key = '0;
        check_latency("fips_latency");
        check_all("fips");
        KeySel = 4'd10;
        @(negedge Clk);
        checks++;
        if (RoundKey !== FIPS_RK10) begin
            errors++;
            $display("FAIL fips_rk10 got %h expected %h", RoundKey, FIPS_RK10);
        end
    endtask

    task automatic test_keysel();
        KeySel = 4'd1;
        @(negedge Clk);
        KeySel = 4'd12;
        #1;
        checks++;
`ifdef KEYEXP_REGOUT_EN
        if (RoundKey !== exp_rk[1]) begin
            errors++;
            $display("FAIL keysel_lag got %h expected %h", RoundKey, exp_rk[1]);
        end
`else
        if (RoundKey !== 128'h0) begin
            errors++;
            $display("FAIL keysel_comb got %h expected 0", RoundKey);
        end
`endif
        @(negedge Clk);
        KeySel = 4'd3;
        #1;
        checks++;
`ifdef KEYEXP_REGOUT_EN
        if (RoundKey !== 128'h0) begin
            errors++;
            $display("FAIL keysel_lag2 got %h expected 0", RoundKey);
        end
`else
        if (RoundKey !== exp_rk[3]) begin
            errors++;
            $display("FAIL keysel_comb2 got %h expected %h", RoundKey, exp_rk[3]);
        end
`endif
        @(negedge Clk);
        for (int s = 11; s < 16; s++) begin
            KeySel = 4'(s);
            @(negedge Clk);
            checks++;
            if (RoundKey !== 128'h0) begin
                errors++;
                $display("FAIL keysel_oob[%0d] got %h expected 0", s, RoundKey);
            end
        end
        KeySel = '0;
    endtask

    task automatic test_busy_ignore();
        model_expand(FIPS_KEY);
        start_exp(FIPS_KEY);
        for (int i = 0; i < 4; i++) begin
            start_exp(128'h0);
            @(negedge Clk);
        end
        wait_ready("ignore_wait");
        check_all("busy_ignore");
    endtask

    task automatic test_mid_reset();
        start_exp({$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Ry !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flags Busy=%b Ry=%b expected 0 0", Busy, Ry);
        end
        model_clear();
        check_all("mid_reset_storage");
        model_expand(SEQ_KEY);
        start_exp(SEQ_KEY);
        check_latency("seq_latency");
        check_all("seq");
        KeySel = 4'd10;
        @(negedge Clk);
        checks++;
        if (RoundKey !== SEQ_RK10) begin
            errors++;
            $display("FAIL seq_rk10 got %h expected %h", RoundKey, SEQ_RK10);
        end
        KeySel = '0;
    endtask

    task automatic test_restart();
        logic [127:0] k;
        for (int n = 0; n < 3; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            start_exp(k);
            Key = {$urandom, $urandom, $urandom, $urandom};
            check_latency("restart_latency");
            check_all("restart");
        end
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_fips();
        test_keysel();
        test_busy_ignore();
        test_mid_reset();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
